verificador_senha: RTL



---
 rtl/verificador_senha.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/verificador_senha.sv
// Four-digit BCD password checker fed by the keypad scanner.
// Optional master-code unlock is built when SENHA_MESTRA_EN is defined.
module verificador_senha #(
  parameter int          ABERTO_CICLOS   = 50000000,
  parameter int          ERRO_CICLOS     = 25000000,
  parameter int          BLOQUEIO_CICLOS = 500000000,
  parameter int          MAX_TENTATIVAS  = 3,
  parameter int          CONT_W          = 30,
  parameter logic [15:0] SENHA_MESTRA    = 16'h9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] registrador_w,
  input  logic        salve,
  output logic        aberto,
  output logic        erro,
  output logic        bloqueado,
  output logic        senha_definida,
  output logic [2:0]  tentativas,
  output logic [2:0]  estado
);

  typedef enum logic [2:0] {
    SEM_SENHA = 3'd0,
    TRAVADO   = 3'd1,
    ABERTO    = 3'd2,
    ERRO      = 3'd3,
    BLOQUEIO  = 3'd4
  } estado_t;

  localparam logic [CONT_W-1:0] T_AB = CONT_W'(ABERTO_CICLOS - 1);
  localparam logic [CONT_W-1:0] T_ER = CONT_W'(ERRO_CICLOS - 1);
  localparam logic [CONT_W-1:0] T_BL = CONT_W'(BLOQUEIO_CICLOS - 1);
  localparam logic [2:0]        MAX_T = 3'(MAX_TENTATIVAS);

  estado_t           st_q, st_d;
  estado_t           ret_q, ret_d;
  logic [15:0]       senha_q, senha_d;
  logic [CONT_W-1:0] timer_q, timer_d;
  logic [2:0]        tent_q, tent_d;
  logic              def_q, def_d;
  logic              salve_q;

  logic       ent;
  logic       valido;
  logic       acerto;
  logic       mestra;
  logic       fim;
  logic [2:0] tent_inc;

  assign ent    = salve & ~salve_q;
  assign valido = (registrador_w[15:12] <= 4'd9) &&
                  (registrador_w[11:8]  <= 4'd9) &&
                  (registrador_w[7:4]   <= 4'd9) &&
                  (registrador_w[3:0]   <= 4'd9);
  assign acerto = registrador_w == senha_q;
  assign fim    = timer_q == '0;
  assign tent_inc = (tent_q >= MAX_T) ? MAX_T : tent_q + 3'd1;

`ifdef SENHA_MESTRA_EN
  assign mestra = ent && (registrador_w == SENHA_MESTRA);
`else
  logic unused_mestra;
  assign unused_mestra = ^SENHA_MESTRA;
  assign mestra = 1'b0;
`endif

  always_comb begin
    st_d    = st_q;
    ret_d   = ret_q;
    senha_d = senha_q;
    timer_d = timer_q;
    tent_d  = tent_q;
    def_d   = def_q;
    unique case (st_q)
      SEM_SENHA: begin
        if (ent && valido) begin
          senha_d = registrador_w;
          def_d   = 1'b1;
          st_d    = TRAVADO;
        end else if (ent) begin
          st_d    = ERRO;
          ret_d   = SEM_SENHA;
          timer_d = T_ER;
        end
      end
      TRAVADO: begin
        if (ent && (acerto || mestra)) begin
          tent_d  = '0;
          st_d    = ABERTO;
          timer_d = T_AB;
        end else if (ent) begin
          tent_d = tent_inc;
          if (tent_inc == MAX_T) begin
            st_d    = BLOQUEIO;
            timer_d = T_BL;
          end else begin
            st_d    = ERRO;
            ret_d   = TRAVADO;
            timer_d = T_ER;
          end
        end
      end
      ABERTO: begin
        // A fresh entry wins over the expiring timer.
        if (ent && valido) begin
          senha_d = registrador_w;
          st_d    = TRAVADO;
        end else if (ent) begin
          st_d    = ERRO;
          ret_d   = TRAVADO;
          timer_d = T_ER;
        end else if (fim) begin
          st_d = TRAVADO;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ERRO: begin
        if (fim) st_d = ret_q;
        else timer_d = timer_q - 1'b1;
      end
      BLOQUEIO: begin
        if (mestra) begin
          tent_d  = '0;
          st_d    = ABERTO;
          timer_d = T_AB;
        end else if (fim) begin
          tent_d = '0;
          st_d   = TRAVADO;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: st_d = SEM_SENHA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= SEM_SENHA;
      ret_q   <= SEM_SENHA;
      senha_q <= '0;
      timer_q <= '0;
      tent_q  <= '0;
      def_q   <= 1'b0;
      salve_q <= 1'b1;
    end else begin
      st_q    <= st_d;
      ret_q   <= ret_d;
      senha_q <= senha_d;
      timer_q <= timer_d;
      tent_q  <= tent_d;
      def_q   <= def_d;
      salve_q <= salve;
    end
  end

  assign aberto         = st_q == ABERTO;
  assign erro           = st_q == ERRO;
  assign bloqueado      = st_q == BLOQUEIO;
  assign senha_definida = def_q;
  assign tentativas     = tent_q;
  assign estado         = st_q;

endmodule
